// File: rtl/wordle_guess_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : wordle_guess_ctrl                                                |
// | Function : Collects one guess row and scores it two-pass against target.    |
// |            Optional macro WORDLE_HARD_MODE_EN keeps known greens enforced.  |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module wordle_guess_ctrl #(
  parameter int MAX_GUESSES = 6
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        letter_valid,
  input  logic [4:0]  letter,
  input  logic        del,
  input  logic        submit,
  input  logic        new_game,
  input  logic [24:0] target,
  output logic [2:0]  row,
  output logic [2:0]  col,
  output logic [24:0] guess_word,
  output logic [9:0]  score,
  output logic        score_valid,
  output logic        reject,
  output logic        busy,
  output logic        win,
  output logic        lose
);

  localparam logic [2:0] c_LAST_ROW = 3'(MAX_GUESSES - 1);

  typedef enum logic [2:0] {
    S_ENTRY  = 3'd0,
    S_GREEN  = 3'd1,
    S_YELLOW = 3'd2,
    S_REPORT = 3'd3,
    S_WON    = 3'd4,
    S_LOST   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_row;
  logic [2:0]  r_col;
  logic [24:0] r_guess;
  logic [9:0]  r_score;
  logic [4:0]  r_used;
  logic [2:0]  r_idx;
  logic        r_reject;

  logic [4:0]  w_g_letter;
  logic [4:0]  w_t_letter;
  logic [1:0]  w_score_cur;
  logic        w_found;
  logic [2:0]  w_j;
  logic        w_hard_bad;
  logic        w_submit_ok;

  always_comb begin
    w_g_letter  = '0;
    w_t_letter  = '0;
    w_score_cur = '0;
    for (int i = 0; i < 5; i++) begin
      if (r_idx == 3'(i)) begin
        w_g_letter  = r_guess[5*i +: 5];
        w_t_letter  = target[5*i +: 5];
        w_score_cur = r_score[2*i +: 2];
      end
    end
  end

  // Descending scan so the lowest unused matching position wins.
  always_comb begin
    w_found = 1'b0;
    w_j     = '0;
    for (int j = 4; j >= 0; j--) begin
      if (!r_used[j] && (target[5*j +: 5] == w_g_letter)) begin
        w_found = 1'b1;
        w_j     = 3'(j);
      end
    end
  end

`ifdef WORDLE_HARD_MODE_EN
  logic [4:0]  r_green_mask;
  logic [24:0] r_green_letters;
  logic [4:0]  w_diff;

  always_comb begin
    w_diff = '0;
    for (int i = 0; i < 5; i++) begin
      w_diff[i] = (r_guess[5*i +: 5] != r_green_letters[5*i +: 5]);
    end
    w_hard_bad = |(r_green_mask & w_diff);
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_green_mask    <= '0;
      r_green_letters <= '0;
    end else if (((r_state == S_WON) || (r_state == S_LOST)) && new_game) begin
      r_green_mask    <= '0;
      r_green_letters <= '0;
    end else if (r_state == S_REPORT) begin
      for (int i = 0; i < 5; i++) begin
        if (r_score[2*i +: 2] == 2'b11) begin
          r_green_mask[i]           <= 1'b1;
          r_green_letters[5*i +: 5] <= r_guess[5*i +: 5];
        end
      end
    end
  end
`else
  assign w_hard_bad = 1'b0;
`endif

  assign w_submit_ok = (r_col == 3'd5) && !w_hard_bad;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) r_state <= S_ENTRY;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    score_valid  = 1'b0;
    win          = 1'b0;
    lose         = 1'b0;
    case (r_state)
      S_ENTRY:  if (!del && submit && w_submit_ok) w_state_next = S_GREEN;
      S_GREEN: begin
        busy = 1'b1;
        if (r_idx == 3'd4) w_state_next = S_YELLOW;
      end
      S_YELLOW: begin
        busy = 1'b1;
        if (r_idx == 3'd4) w_state_next = S_REPORT;
      end
      S_REPORT: begin
        score_valid = 1'b1;
        if (r_score == 10'h3FF)       w_state_next = S_WON;
        else if (r_row == c_LAST_ROW) w_state_next = S_LOST;
        else                          w_state_next = S_ENTRY;
      end
      S_WON: begin
        win = 1'b1;
        if (new_game) w_state_next = S_ENTRY;
      end
      S_LOST: begin
        lose = 1'b1;
        if (new_game) w_state_next = S_ENTRY;
      end
      default: w_state_next = S_ENTRY;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_row    <= '0;
      r_col    <= '0;
      r_guess  <= '0;
      r_score  <= '0;
      r_used   <= '0;
      r_idx    <= '0;
      r_reject <= 1'b0;
    end else begin
      r_reject <= 1'b0;
      case (r_state)
        S_ENTRY: begin
          if (del) begin
            if (r_col != 3'd0) begin
              r_col <= r_col - 3'd1;
              for (int i = 0; i < 5; i++) begin
                if (r_col == 3'(i + 1)) r_guess[5*i +: 5] <= 5'd0;
              end
            end
          end else if (submit) begin
            if (w_submit_ok) begin
              r_used  <= '0;
              r_score <= '0;
              r_idx   <= '0;
            end else begin
              r_reject <= 1'b1;
            end
          end else if (letter_valid && (r_col < 3'd5) && (letter <= 5'd25)) begin
            r_col <= r_col + 3'd1;
            for (int i = 0; i < 5; i++) begin
              if (r_col == 3'(i)) r_guess[5*i +: 5] <= letter;
            end
          end
        end
        S_GREEN: begin
          if (w_g_letter == w_t_letter) begin
            for (int i = 0; i < 5; i++) begin
              if (r_idx == 3'(i)) begin
                r_score[2*i +: 2] <= 2'b11;
                r_used[i]         <= 1'b1;
              end
            end
          end
          r_idx <= (r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1;
        end
        S_YELLOW: begin
          if (w_score_cur != 2'b11) begin
            for (int i = 0; i < 5; i++) begin
              if (r_idx == 3'(i)) r_score[2*i +: 2] <= w_found ? 2'b10 : 2'b01;
              if (w_found && (w_j == 3'(i))) r_used[i] <= 1'b1;
            end
          end
          r_idx <= (r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1;
        end
        S_REPORT: begin
          if ((r_score != 10'h3FF) && (r_row != c_LAST_ROW)) begin
            r_row   <= r_row + 3'd1;
            r_col   <= '0;
            r_guess <= '0;
          end
        end
        S_WON, S_LOST: begin
          if (new_game) begin
            r_row   <= '0;
            r_col   <= '0;
            r_guess <= '0;
            r_score <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign row        = r_row;
  assign col        = r_col;
  assign guess_word = r_guess;
  assign score      = r_score;
  assign reject     = r_reject;

endmodule
`default_nettype wire
